// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_core transmitter
// among NREQ byte-stream requesters. The block owns the uart_core register
// write port. It programs the control word, loads the TX byte, enables TX,
// waits for intr_tx or a 16-bit-time timeout, and then disables TX.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/data_i    per-requester byte offer (byte k at [8k+7:8k])
//   req_ready_o           one-hot accept strobe (combinational, IDLE only)
//   cfg_update_i/...      pulse capturing a new baud divisor / rx enable
//   grant_o               one-hot owner of the byte in flight, 0 when idle
//   busy_o                high outside IDLE
//   done_o, timeout_o     1-cycle byte-finished / byte-abandoned pulses
//   u_we_o..u_wdata_o     uart_core register write port (u_ren_o tied 0)
//   u_intr_tx_i           uart_core TX-complete interrupt
module uart_tx_sched #(
  parameter int unsigned NREQ             = 4,
  parameter logic [15:0] DEF_CLKS_PER_BIT = 16'd868,
  parameter logic        DEF_RX_EN        = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              cfg_update_i,
  input  logic [15:0]       cfg_clks_per_bit_i,
  input  logic              cfg_rx_en_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              u_we_o,
  output logic              u_ren_o,
  output logic [3:0]        u_addr_o,
  output logic [31:0]       u_wdata_o,
  input  logic              u_intr_tx_i
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_START,
    S_WAIT,
    S_STOP
  } state_t;

  state_t          state_q, state_d;

  logic [15:0]     act_cpb_q;
  logic            act_rx_q;
  logic [15:0]     pend_cpb_q;
  logic            pend_rx_q;
  logic            pend_q;
  logic [PW-1:0]   ptr_q;
  logic [7:0]      byte_q;
  logic [19:0]     timer_q;
  logic [NREQ-1:0] grant_q;

  logic [PW-1:0]   cand;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic [NREQ-1:0] pick_onehot;
  logic            accept;
  logic [19:0]     timer_limit;
  logic [31:0]     cw_off;
  logic [31:0]     cw_on;

  logic            we_c;
  logic [3:0]      addr_c;
  logic [31:0]     wdata_c;
  logic            done_c;
  logic            timeout_c;

  // Walk forward from the last winner, wrapping, and take the first valid.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + PW'(1);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_onehot = NREQ'(1) << pick_idx;
  // Pending config outranks requests; reset suppresses any accept.
  assign accept      = (state_q == S_IDLE) && !pend_q && pick_found && !rst_i;
  assign timer_limit = {act_cpb_q, 4'b0000} - 20'd1;
  assign cw_off      = {13'b0, act_cpb_q, 1'b0, act_rx_q, 1'b0};
  assign cw_on       = {13'b0, act_cpb_q, 1'b0, act_rx_q, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      S_INIT: begin
        we_c    = 1'b1;
        wdata_c = cw_off;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_CFG;
        end else if (pick_found) begin
          state_d = S_LOAD;
        end
      end
      S_CFG: begin
        we_c    = 1'b1;
        wdata_c = cw_off;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        we_c    = 1'b1;
        addr_c  = 4'd4;
        wdata_c = {24'b0, byte_q};
        state_d = S_START;
      end
      S_START: begin
        we_c    = 1'b1;
        wdata_c = cw_on;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (u_intr_tx_i) begin
          done_c  = 1'b1;
          state_d = S_STOP;
        end else if (timer_q == timer_limit) begin
          timeout_c = 1'b1;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        we_c    = 1'b1;
        wdata_c = cw_off;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_cpb_q  <= DEF_CLKS_PER_BIT;
      act_rx_q   <= DEF_RX_EN;
      pend_cpb_q <= '0;
      pend_rx_q  <= 1'b0;
      pend_q     <= 1'b0;
      ptr_q      <= PW'(NREQ - 1);
      byte_q     <= '0;
      timer_q    <= '0;
      grant_q    <= '0;
    end else begin
      if (state_q == S_IDLE && pend_q) begin
        act_cpb_q <= pend_cpb_q;
        act_rx_q  <= pend_rx_q;
        pend_q    <= 1'b0;
      end
      if (accept) begin
        byte_q  <= req_data_i[{pick_idx, 3'b000} +: 8];
        ptr_q   <= pick_idx;
        grant_q <= pick_onehot;
      end
      if (state_q == S_START) begin
        timer_q <= '0;
      end else if (state_q == S_WAIT) begin
        timer_q <= timer_q + 20'd1;
      end
      if (state_q == S_STOP) begin
        grant_q <= '0;
      end
      // Placed last so a pulse landing in the consume cycle re-arms pending.
      if (cfg_update_i && cfg_clks_per_bit_i != '0) begin
        pend_cpb_q <= cfg_clks_per_bit_i;
        pend_rx_q  <= cfg_rx_en_i;
        pend_q     <= 1'b1;
      end
    end
  end

  assign req_ready_o = accept ? pick_onehot : '0;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE) && !rst_i;
  assign done_o      = done_c && !rst_i;
  assign timeout_o   = timeout_c && !rst_i;
  assign u_we_o      = we_c && !rst_i;
  assign u_ren_o     = 1'b0;
  assign u_addr_o    = rst_i ? '0 : addr_c;
  assign u_wdata_o   = rst_i ? '0 : wdata_c;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           cfg_update_i;
  logic [15:0]    cfg_clks_per_bit_i;
  logic           cfg_rx_en_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           done_o;
  logic           timeout_o;
  logic           u_we_o;
  logic           u_ren_o;
  logic [3:0]     u_addr_o;
  logic [31:0]    u_wdata_o;
  logic           u_intr_tx_i;

  uart_tx_sched #(
    .NREQ(N),
    .DEF_CLKS_PER_BIT(16'd868),
    .DEF_RX_EN(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .cfg_update_i(cfg_update_i),
    .cfg_clks_per_bit_i(cfg_clks_per_bit_i),
    .cfg_rx_en_i(cfg_rx_en_i),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o),
    .u_we_o(u_we_o),
    .u_ren_o(u_ren_o),
    .u_addr_o(u_addr_o),
    .u_wdata_o(u_wdata_o),
    .u_intr_tx_i(u_intr_tx_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input string why);
    total++;
    bad++;
    $display("FAIL %s: got %s (cycle %0d)", name, why, cyc);
  endtask

  // ---------------- expected-response queues ----------------
  typedef struct { int c; logic [3:0] addr; logic [31:0] data; logic [N-1:0] gnt; } wr_t;
  typedef struct { int c; logic [N-1:0] vec; } acc_t;
  typedef struct { int c; bit is_to; logic [N-1:0] gnt; } evt_t;

  wr_t  exp_wr[$];
  acc_t exp_acc[$];
  evt_t exp_evt[$];

  task automatic push_wr(input int c, input logic [3:0] a, input logic [31:0] d, input logic [N-1:0] g);
    wr_t t;
    t.c = c; t.addr = a; t.data = d; t.gnt = g;
    exp_wr.push_back(t);
  endtask

  task automatic push_acc(input int c, input logic [N-1:0] v);
    acc_t t;
    t.c = c; t.vec = v;
    exp_acc.push_back(t);
  endtask

  task automatic push_evt(input int c, input bit is_to, input logic [N-1:0] g);
    evt_t t;
    t.c = c; t.is_to = is_to; t.gnt = g;
    exp_evt.push_back(t);
  endtask

  function automatic logic [31:0] cw(input int cpb, input bit rx, input bit tx);
    return 32'(cpb * 8 + (rx ? 2 : 0) + (tx ? 1 : 0));
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int m_cpb, m_pcpb, m_ptr, m_idle_at, m_wait_start, m_owner, k, j, c;
  bit m_rx, m_prx, m_pend, m_after_rst, m_in_wait;
  logic [7:0] b;

  initial begin : model
    forever begin
      @(negedge clk);
      c = cyc;
      if (rst_i) begin
        exp_wr.delete();
        exp_acc.delete();
        exp_evt.delete();
        m_cpb = 868; m_rx = 0;
        m_pend = 0; m_pcpb = 0; m_prx = 0;
        m_ptr = N - 1;
        m_after_rst = 1;
        m_in_wait = 0;
        m_idle_at = 32'h7fffffff;
      end else begin
        if (m_after_rst) begin
          push_wr(c, 4'd0, cw(m_cpb, m_rx, 0), '0);
          m_idle_at = c + 1;
          m_after_rst = 0;
        end else if (m_in_wait) begin
          if (c >= m_wait_start) begin
            if (u_intr_tx_i || (c - m_wait_start == 16 * m_cpb - 1)) begin
              push_evt(c, !u_intr_tx_i, oh(m_owner));
              push_wr(c + 1, 4'd0, cw(m_cpb, m_rx, 0), oh(m_owner));
              m_idle_at = c + 2;
              m_in_wait = 0;
            end
          end
        end else if (c >= m_idle_at) begin
          if (m_pend) begin
            m_cpb = m_pcpb; m_rx = m_prx; m_pend = 0;
            push_wr(c + 1, 4'd0, cw(m_cpb, m_rx, 0), '0);
            m_idle_at = c + 2;
          end else begin
            k = -1;
            for (int d = 1; d <= N; d++) begin
              j = (m_ptr + d) % N;
              if (k < 0 && req_valid_i[j]) k = j;
            end
            if (k >= 0) begin
              b = req_data_i[8*k +: 8];
              push_acc(c, oh(k));
              push_wr(c + 1, 4'd4, {24'd0, b}, oh(k));
              push_wr(c + 2, 4'd0, cw(m_cpb, m_rx, 1), oh(k));
              m_ptr = k; m_owner = k;
              m_in_wait = 1;
              m_wait_start = c + 3;
            end
          end
        end
        if (cfg_update_i && cfg_clks_per_bit_i != 16'd0) begin
          m_pend = 1; m_pcpb = int'(cfg_clks_per_bit_i); m_prx = cfg_rx_en_i;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  wr_t  ew;
  acc_t ea;
  evt_t ee;
  bit   prev_rst;

  initial begin : monitor
    prev_rst = 1;
    forever begin
      @(negedge clk);
      #1;
      while (exp_wr.size() > 0 && exp_wr[0].c < cyc) begin
        fail_evt("wr_missing", $sformatf("no write, want one at cycle %0d", exp_wr[0].c));
        void'(exp_wr.pop_front());
      end
      while (exp_acc.size() > 0 && exp_acc[0].c < cyc) begin
        fail_evt("acc_missing", $sformatf("no accept, want one at cycle %0d", exp_acc[0].c));
        void'(exp_acc.pop_front());
      end
      while (exp_evt.size() > 0 && exp_evt[0].c < cyc) begin
        fail_evt("evt_missing", $sformatf("no done/timeout, want one at cycle %0d", exp_evt[0].c));
        void'(exp_evt.pop_front());
      end
      if (prev_rst) begin
        check("rst_grant", grant_o, '0);
        if (rst_i)
          check("rst_outs", {busy_o, u_we_o, u_ren_o, u_addr_o, u_wdata_o, req_ready_o, done_o, timeout_o}, '0);
      end
      if (u_we_o) begin
        if (exp_wr.size() == 0 || exp_wr[0].c != cyc) begin
          fail_evt("wr_unexpected", $sformatf("addr %0h data %0h, want no write", u_addr_o, u_wdata_o));
        end else begin
          ew = exp_wr.pop_front();
          check("wr_addr", u_addr_o, ew.addr);
          check("wr_data", u_wdata_o, ew.data);
          check("wr_grant", grant_o, ew.gnt);
          check("wr_busy_ren", {busy_o, u_ren_o}, 2'b10);
        end
      end
      if (req_ready_o != '0) begin
        if (exp_acc.size() == 0 || exp_acc[0].c != cyc) begin
          fail_evt("acc_unexpected", $sformatf("ready %b, want none", req_ready_o));
        end else begin
          ea = exp_acc.pop_front();
          check("acc_vec", req_ready_o, ea.vec);
        end
      end
      if (done_o || timeout_o) begin
        if (exp_evt.size() == 0 || exp_evt[0].c != cyc) begin
          fail_evt("evt_unexpected", $sformatf("done %b timeout %b, want none", done_o, timeout_o));
        end else begin
          ee = exp_evt.pop_front();
          check("evt_kind", {done_o, timeout_o}, ee.is_to ? 2'b01 : 2'b10);
          check("evt_grant", grant_o, ee.gnt);
        end
      end
      prev_rst = rst_i;
    end
  end

  // ---------------- uart_core interrupt responder ----------------
  int intr_delay = -1;
  bit rand_mode  = 0;
  bit stray_en   = 0;

  initial begin : responder
    int off, dly;
    bit saw;
    off = -1; dly = -1;
    u_intr_tx_i = 1'b0;
    forever begin
      @(negedge clk);
      saw = u_we_o && (u_addr_o == 4'd0) && u_wdata_o[0];
      @(posedge clk);
      #1;
      if (saw) begin
        off = 0;
        if (rand_mode) dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 100));
        else dly = intr_delay;
      end else if (off >= 0) begin
        off++;
      end
      u_intr_tx_i = ((off >= 0) && (off == dly)) || (stray_en && ($urandom_range(0, 19) == 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (|req_ready_o) break;
      n++;
      if (n >= budget) begin
        fail_evt("accept_wait", "no req_ready_o within budget");
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
      if (n >= budget) begin
        fail_evt("idle_wait", "busy_o still high after budget");
        break;
      end
    end
    tick();
  endtask

  task automatic cfg_pulse(input int cpb, input bit rx);
    cfg_update_i = 1'b1;
    cfg_clks_per_bit_i = 16'(cpb);
    cfg_rx_en_i = rx;
    tick();
    cfg_update_i = 1'b0;
  endtask

  initial begin : stim
    int cnt, n;
    rst_i = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    cfg_update_i = 1'b0;
    cfg_clks_per_bit_i = '0;
    cfg_rx_en_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (6) tick();

    // single request from requester 2
    intr_delay = 20;
    req_data_i[23:16] = 8'h5A;
    req_valid_i = 4'b0100;
    wait_accept(10);
    req_valid_i = '0;
    wait_idle(100);

    // all requesters continuously valid
    intr_delay = 4;
    for (int i = 0; i < N; i++) req_data_i[8*i +: 8] = 8'($urandom);
    req_valid_i = '1;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 100) begin
      @(negedge clk);
      if (|req_ready_o) cnt++;
      n++;
    end
    check("rr_accept_count", cnt, 5);
    tick();
    req_valid_i = '0;
    wait_idle(100);

    // config update while a byte is in flight
    intr_delay = 10;
    req_data_i[15:8] = 8'hC3;
    req_valid_i = 4'b0010;
    wait_accept(10);
    req_valid_i = '0;
    repeat (5) tick();
    cfg_pulse(16, 1'b1);
    wait_idle(100);
    req_data_i[7:0] = 8'h3C;
    req_valid_i = 4'b0001;
    wait_accept(10);
    req_valid_i = '0;
    wait_idle(100);

    // timeout, then intr landing on the timeout cycle
    intr_delay = -1;
    req_data_i[31:24] = 8'h11;
    req_valid_i = 4'b1000;
    wait_accept(10);
    req_valid_i = '0;
    wait_idle(400);
    intr_delay = 255;
    req_data_i[23:16] = 8'h22;
    req_valid_i = 4'b0100;
    wait_accept(10);
    req_valid_i = '0;
    wait_idle(400);

    // reset in WAIT, then a zero-divisor update that must be ignored
    intr_delay = -1;
    req_valid_i = 4'b0001;
    wait_accept(10);
    req_valid_i = '0;
    repeat (8) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    wait_idle(20);
    cfg_pulse(0, 1'b1);
    repeat (10) tick();
    cfg_pulse(3, 1'b0);
    repeat (4) tick();

    // randomized traffic
    rand_mode = 1;
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      req_valid_i = N'($urandom) & N'($urandom);
      req_data_i = 32'($urandom);
      cfg_update_i = ($urandom_range(0, 49) == 0);
      cfg_clks_per_bit_i = 16'($urandom_range(0, 6));
      cfg_rx_en_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        cfg_update_i = 1'b1;
        cfg_clks_per_bit_i = 16'($urandom_range(1, 6));
      end
      tick();
    end
    req_valid_i = '0;
    cfg_update_i = 1'b0;
    stray_en = 0;
    rand_mode = 0;
    intr_delay = 0;
    wait_idle(300);
    repeat (6) tick();

    check("end_wr_queue", exp_wr.size(), 0);
    check("end_acc_queue", exp_acc.size(), 0);
    check("end_evt_queue", exp_evt.size(), 0);
    check("end_idle", {busy_o, grant_o}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
